// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, operand sources, flag bit indices, FSM states.
// Imported by the ALU, its interface, the control unit and the benches.
package alu_pkg;

    typedef enum logic [2:0] {
        RA    = 3'd0,
        RB    = 3'd1,
        RADD  = 3'd2,
        RSUB  = 3'd3,
        RMULL = 3'd4,
        RMULH = 3'd5,
        RAND  = 3'd6,
        ROR   = 3'd7
    } func_t;

    typedef enum logic [1:0] {
        REG   = 2'd0,
        SW_LO = 2'd1,
        SW_HI = 2'd2,
        IMM   = 2'd3
    } src_t;

    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU.
// master: start, func, a_sel, b_sel, a_in, b_in, switches, immediate out;
//         busy, done, result, flags in.  slave: the mirror image (the ALU).
interface alu_mc_if #(
    parameter int N     = 8,
    parameter int IMM_W = 8
);
    import alu_pkg::*;

    logic             start;
    func_t            func;
    src_t             a_sel;
    src_t             b_sel;
    logic [N-1:0]     a_in;
    logic [N-1:0]     b_in;
    logic [N:0]       switches;
    logic [IMM_W-1:0] immediate;
    logic             busy;
    logic             done;
    logic [N-1:0]     result;
    logic [3:0]       flags;

    modport master (
        output start, func, a_sel, b_sel, a_in, b_in, switches, immediate,
        input  busy, done, result, flags
    );

    modport slave (
        input  start, func, a_sel, b_sel, a_in, b_in, switches, immediate,
        output busy, done, result, flags
    );

endinterface

// File: rtl/mul_iter.sv
// Unsigned N x N shift-add multiplier core, one partial product per step.
// Ports: clk, reset, load (latch a_mag/b_mag), step, prod (2N), last.
module mul_iter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a_mag,
    input  logic [N-1:0]   b_mag,
    output logic [2*N-1:0] prod,
    output logic           last
);

    localparam int CW = $clog2(N);

    logic [N-1:0]   mcand;
    logic [2*N-1:0] p;
    logic [CW-1:0]  cnt;
    logic [N:0]     sum;

    // Upper half accumulates; lower half starts as the multiplier and
    // is shifted out one bit per step as product bits shift in.
    assign sum  = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, mcand} : '0);
    assign prod = p;
    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            p     <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= a_mag;
            p     <= {{N{1'b0}}, b_mag};
            cnt   <= '0;
        end else if (step) begin
            p     <= {sum, p[N-1:1]};
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle simple ops, N-cycle signed MULL/MULH.
// Ports: clk, reset (sync, active-high), bus (alu_mc_if.slave).
module alu_mc
    import alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int IMM_W = 8
) (
    input  logic    clk,
    input  logic    reset,
    alu_mc_if.slave bus
);

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   a_op;
    logic [N-1:0]   b_op;
    logic [N-1:0]   imm_ext;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [N:0]     add_s;
    logic [N:0]     sub_s;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] p_fin;
    logic           last;
    logic           load;
    logic           step;
    logic           wr_simple;
    logic           wr_mul;
    logic           is_mul;
    logic           sign_q;
    logic           mulh_q;
    logic [N-1:0]   res_d;
    logic [3:0]     flg_d;
    logic           v_d;
    logic           c_d;
    logic [N-1:0]   result_q;
    logic [3:0]     flags_q;
    logic           done_q;

    assign imm_ext = N'($signed(bus.immediate[IMM_W-1:0]));

    always_comb begin
        a_op = bus.a_in;
        b_op = bus.b_in;
        unique case (bus.a_sel)
            SW_LO:   a_op = bus.switches[N-1:0];
            SW_HI:   a_op = {N{bus.switches[N]}};
            default: a_op = bus.a_in;
        endcase
        unique case (bus.b_sel)
            SW_LO:   b_op = bus.switches[N-1:0];
            SW_HI:   b_op = {N{bus.switches[N]}};
            IMM:     b_op = imm_ext;
            default: b_op = bus.b_in;
        endcase
    end

    // -2^(N-1) negates to itself, which read unsigned is the exact magnitude.
    assign a_mag = a_op[N-1] ? -a_op : a_op;
    assign b_mag = b_op[N-1] ? -b_op : b_op;
    assign p_fin = sign_q ? -prod : prod;

    assign add_s = {1'b0, a_op} + {1'b0, b_op};
    assign sub_s = {1'b0, a_op} + {1'b0, ~b_op} + (N + 1)'(1);

    assign is_mul = (bus.func == RMULL) || (bus.func == RMULH);

    mul_iter #(.N(N)) u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .prod  (prod),
        .last  (last)
    );

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        wr_simple = 1'b0;
        wr_mul    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_mul) begin
                        load    = 1'b1;
                        state_d = MUL;
                    end else begin
                        wr_simple = 1'b1;
                    end
                end
            end
            MUL: begin
                step = 1'b1;
                if (last) state_d = FIN;
            end
            FIN: begin
                wr_mul  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // In FIN the op is taken from the latched MULH bit, not the live func.
    always_comb begin
        res_d = '0;
        v_d   = 1'b0;
        c_d   = 1'b0;
        if (state_q == FIN) begin
            if (mulh_q) begin
                res_d = p_fin[2*N-1:N];
            end else begin
                res_d = p_fin[N-1:0];
                v_d   = (p_fin[2*N-1:N] != {N{p_fin[N-1]}});
            end
        end else begin
            unique case (bus.func)
                RA:   res_d = a_op;
                RB:   res_d = b_op;
                RADD: begin
                    res_d = add_s[N-1:0];
                    c_d   = add_s[N];
                    v_d   = (a_op[N-1] == b_op[N-1]) &&
                            (add_s[N-1] != a_op[N-1]);
                end
                RSUB: begin
                    res_d = sub_s[N-1:0];
                    c_d   = sub_s[N];
                    v_d   = (a_op[N-1] != b_op[N-1]) &&
                            (sub_s[N-1] != a_op[N-1]);
                end
                RAND: res_d = a_op & b_op;
                ROR:  res_d = a_op | b_op;
                default: res_d = '0;
            endcase
        end
        flg_d         = '0;
        flg_d[FLAG_V] = v_d;
        flg_d[FLAG_N] = res_d[N-1];
        flg_d[FLAG_Z] = (res_d == '0);
        flg_d[FLAG_C] = c_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            sign_q   <= 1'b0;
            mulh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= wr_simple | wr_mul;
            if (wr_simple | wr_mul) begin
                result_q <= res_d;
                flags_q  <= flg_d;
            end
            if (load) begin
                sign_q <= a_op[N-1] ^ b_op[N-1];
                mulh_q <= (bus.func == RMULH);
            end
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: an N=8 instance for the bulk of the vectors
// and an N=16 instance for the wide multiply.
module tb_alu_mc;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    alu_mc_if #(.N(8), .IMM_W(8))  b8 ();
    alu_mc_if #(.N(16), .IMM_W(8)) b16 ();

    alu_mc #(.N(8), .IMM_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    alu_mc #(.N(16), .IMM_W(8)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b16)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [19:0] q8[$];
    logic [19:0] q16[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(int n, longint u);
        return (u >= (longint'(1) << (n - 1))) ? u - (longint'(1) << n) : u;
    endfunction

    // Returns {V,N,Z,C, result[15:0]} for an n-bit ALU.
    function automatic logic [19:0] model(int n, func_t f,
                                          logic [15:0] a, logic [15:0] b);
        longint m  = (longint'(1) << n) - 1;
        longint ua = longint'(a) & m;
        longint ub = longint'(b) & m;
        longint sa = sx(n, ua);
        longint sb = sx(n, ub);
        longint lo = -(longint'(1) << (n - 1));
        longint hi = (longint'(1) << (n - 1)) - 1;
        longint x  = 0;
        logic   v  = 1'b0;
        logic   c  = 1'b0;
        logic [15:0] r;
        case (f)
            RA:   x = ua;
            RB:   x = ub;
            RAND: x = ua & ub;
            ROR:  x = ua | ub;
            RADD: begin
                x = sa + sb;
                v = (x < lo) || (x > hi);
                c = (ua + ub) > m;
            end
            RSUB: begin
                x = sa - sb;
                v = (x < lo) || (x > hi);
                c = (ua >= ub);
            end
            RMULL: begin
                x = sa * sb;
                v = (x < lo) || (x > hi);
            end
            default: x = (sa * sb) >>> n;
        endcase
        r = 16'(x & m);
        return {v, r[n-1], (r == 16'h0), c, r};
    endfunction

    always @(negedge clk) begin
        logic [19:0] e;
        if (b8.done === 1'b1) begin
            if (q8.size() == 0) begin
                chk("spurious_done8", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("result8", b8.result, e[7:0]);
                chk("flags8", b8.flags, e[19:16]);
            end
        end
        if (b16.done === 1'b1) begin
            if (q16.size() == 0) begin
                chk("spurious_done16", 1, 0);
            end else begin
                e = q16.pop_front();
                chk("result16", b16.result, e[15:0]);
                chk("flags16", b16.flags, e[19:16]);
            end
        end
    end

    task automatic scramble8();
        b8.func      = func_t'($urandom_range(0, 7));
        b8.a_sel     = src_t'($urandom_range(0, 3));
        b8.b_sel     = src_t'($urandom_range(0, 3));
        b8.a_in      = 8'($urandom);
        b8.b_in      = 8'($urandom);
        b8.switches  = 9'($urandom);
        b8.immediate = 8'($urandom);
    endtask

    // Called at a falling edge; returns at the falling edge of the done cycle.
    task automatic issue8(func_t f, src_t as, src_t bs, logic [7:0] a,
                          logic [7:0] b, logic [8:0] sw, logic [7:0] imm);
        logic [15:0] ao;
        logic [15:0] bo;
        int lat;
        bit mul;
        bit busy_ok;
        ao = (as == SW_LO) ? 16'(sw[7:0]) :
             (as == SW_HI) ? {8'h0, {8{sw[8]}}} : 16'(a);
        bo = (bs == SW_LO) ? 16'(sw[7:0]) :
             (bs == SW_HI) ? {8'h0, {8{sw[8]}}} :
             (bs == IMM)   ? 16'(imm) : 16'(b);
        q8.push_back(model(8, f, ao, bo));
        b8.start = 1'b1;
        b8.func = f;
        b8.a_sel = as;
        b8.b_sel = bs;
        b8.a_in = a;
        b8.b_in = b;
        b8.switches = sw;
        b8.immediate = imm;
        @(negedge clk);
        b8.start = 1'b0;
        scramble8();
        mul = (f == RMULL) || (f == RMULH);
        lat = 1;
        busy_ok = 1'b1;
        while (b8.done !== 1'b1 && lat < 40) begin
            if (b8.busy !== mul) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, mul ? 10 : 1);
        chk("busy", busy_ok, 1);
        chk("busy_at_done", b8.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int lat;
        b8.start = 1'b0;
        b8.func = RA;
        b8.a_sel = REG;
        b8.b_sel = REG;
        b8.a_in = '0;
        b8.b_in = '0;
        b8.switches = '0;
        b8.immediate = '0;
        b16.start = 1'b0;
        b16.func = RA;
        b16.a_sel = REG;
        b16.b_sel = REG;
        b16.a_in = '0;
        b16.b_in = '0;
        b16.switches = '0;
        b16.immediate = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", b8.busy, 0);
        chk("rst_done", b8.done, 0);
        chk("rst_result", b8.result, 0);
        chk("rst_flags", b8.flags, 0);
        chk("rst_busy16", b16.busy, 0);
        chk("rst_result16", b16.result, 0);
        reset = 1'b0;
        @(negedge clk);

        issue8(RADD, REG, REG, 8'd127, 8'd127, 9'h0, 8'h0);
        issue8(RADD, REG, REG, 8'd255, 8'd1, 9'h0, 8'h0);
        issue8(RSUB, REG, REG, 8'h80, 8'h01, 9'h0, 8'h0);
        issue8(RSUB, REG, REG, 8'd5, 8'd5, 9'h0, 8'h0);
        issue8(RMULL, REG, REG, 8'd2, 8'hFE, 9'h0, 8'h0);
        issue8(RMULL, REG, REG, 8'd3, 8'h80, 9'h0, 8'h0);
        issue8(RMULH, REG, REG, 8'd3, 8'h80, 9'h0, 8'h0);
        issue8(RMULL, REG, REG, 8'h80, 8'h80, 9'h0, 8'h0);
        issue8(RMULH, REG, REG, 8'h80, 8'h80, 9'h0, 8'h0);
        issue8(RMULL, REG, REG, 8'h00, 8'h9D, 9'h0, 8'h0);
        issue8(RADD, REG, IMM, 8'd125, 8'h00, 9'h0, 8'hFB);
        issue8(RA, SW_HI, REG, 8'h00, 8'h00, 9'h100, 8'h0);
        issue8(RB, IMM, SW_LO, 8'h3C, 8'h00, 9'h0A5, 8'h0);
        issue8(RAND, SW_LO, REG, 8'h00, 8'hF0, 9'h03C, 8'h0);
        issue8(ROR, REG, SW_HI, 8'h12, 8'h00, 9'h000, 8'h0);

        for (int i = 0; i < 12; i++) begin
            issue8(func_t'($urandom_range(0, 7)),
                   src_t'($urandom_range(0, 3)),
                   src_t'($urandom_range(0, 3)),
                   8'($urandom), 8'($urandom),
                   9'($urandom), 8'($urandom));
        end

        // Leave a non-zero result so the reset clear is observable.
        issue8(RA, REG, REG, 8'hFF, 8'h00, 9'h0, 8'h0);
        b8.start = 1'b1;
        b8.func = RMULL;
        b8.a_sel = REG;
        b8.b_sel = REG;
        b8.a_in = 8'd7;
        b8.b_in = 8'd9;
        @(negedge clk);
        b8.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", b8.busy, 0);
        chk("abort_done", b8.done, 0);
        chk("abort_result", b8.result, 0);
        chk("abort_flags", b8.flags, 0);
        reset = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (b8.done === 1'b1) cnt++;
        end
        chk("abort_no_done", cnt, 0);

        q8.push_back(model(8, RMULL, 16'h00FD, 16'h0005));
        b8.start = 1'b1;
        b8.func = RMULL;
        b8.a_in = 8'hFD;
        b8.b_in = 8'h05;
        @(negedge clk);
        b8.start = 1'b0;
        repeat (2) @(negedge clk);
        b8.start = 1'b1;
        b8.func = RADD;
        b8.a_in = 8'd1;
        b8.b_in = 8'd1;
        @(negedge clk);
        b8.start = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (b8.done === 1'b1) cnt++;
        end
        chk("one_done", cnt, 1);

        q16.push_back(model(16, RMULL, 16'd300, 16'hFED4));
        b16.start = 1'b1;
        b16.func = RMULL;
        b16.a_in = 16'd300;
        b16.b_in = 16'hFED4;
        @(negedge clk);
        b16.start = 1'b0;
        b16.a_in = 16'h1234;
        b16.b_in = 16'h0007;
        b16.func = RA;
        lat = 1;
        while (b16.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency16", lat, 18);

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q16_drained", q16.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
